display_sequencer: RTL and testbench



---
 rtl/display_sequencer.sv | 122 ++++++++++++
 tb/tb_display_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// Hex-display source scheduler: chooses instruction, PC or ALU word for the
// eight-digit display under manual, timed-rotation, step-button and freeze control.
module display_sequencer #(
   parameter int unsigned DWELL = 50_000_000,
   parameter int unsigned CNT_W = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_Instruc,
   input  logic [31:0] in_Pc,
   input  logic [31:0] in_Alu,
   input  logic        in_Auto,
   input  logic [1:0]  in_Sel,
   input  logic        in_Freeze,
   input  logic        in_Next,
   output logic [31:0] out_Display,
   output logic [1:0]  out_Source,
   output logic [7:0]  out_Blank,
   output logic        out_Tick
);

   localparam int unsigned       DATA_W   = 32;
   localparam int unsigned       NIBBLES  = DATA_W / 4;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      SRC_INSTR = 2'b00,
      SRC_PC    = 2'b01,
      SRC_ALU   = 2'b10
   } src_e;

   src_e              src_q, src_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              tick_q, tick_d;
   logic              sync1_q, sync2_q, prev_q;
   logic              next_pulse_c;
   src_e              sel_src_c;
   src_e              step_src_c;
   logic [DATA_W-1:0] word_c;

   // State register; the button synchronizer keeps running during freeze so
   // presses made while frozen are consumed rather than queued.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         src_q   <= SRC_INSTR;
         cnt_q   <= '0;
         disp_q  <= '0;
         tick_q  <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         tick_q  <= tick_d;
         sync1_q <= in_Next;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Decode helpers: manual selection, rotation successor, displayed word.
   always_comb begin
      sel_src_c  = SRC_INSTR;
      step_src_c = SRC_INSTR;
      word_c     = in_Instruc;
      case (in_Sel)
         2'b01:   sel_src_c = SRC_PC;
         2'b10:   sel_src_c = SRC_ALU;
         default: sel_src_c = SRC_INSTR;
      endcase
      case (src_q)
         SRC_INSTR: step_src_c = SRC_PC;
         SRC_PC:    step_src_c = SRC_ALU;
         default:   step_src_c = SRC_INSTR;
      endcase
      case (src_q)
         SRC_PC:  word_c = in_Pc;
         SRC_ALU: word_c = in_Alu;
         default: word_c = in_Instruc;
      endcase
   end

   // Next-state: freeze holds everything; a coinciding expiry and button
   // pulse merge into one advance.
   always_comb begin
      src_d        = src_q;
      cnt_d        = cnt_q;
      disp_d       = disp_q;
      tick_d       = 1'b0;
      next_pulse_c = sync2_q & ~prev_q;
      if (!in_Freeze) begin
         disp_d = word_c;
         if (!in_Auto) begin
            src_d = sel_src_c;
            cnt_d = '0;
         end else if ((cnt_q == CNT_LAST) || next_pulse_c) begin
            src_d  = step_src_c;
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Leading-zero blanking, chained down from the most significant digit.
   always_comb begin
      out_Blank              = '0;
      out_Blank[NIBBLES-1]   = ~|disp_q[DATA_W-1 -: 4];
      for (int i = NIBBLES - 2; i >= 1; i--) begin
         out_Blank[i] = out_Blank[i+1] & ~|disp_q[4*i +: 4];
      end
   end

   assign out_Display = disp_q;
   assign out_Source  = src_q;
   assign out_Tick    = tick_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: a cycle-level reference model pushes
// expected outputs per edge; an independent monitor pops and compares.
module tb_display_sequencer;

   localparam int unsigned DW  = 5;
   localparam int unsigned CW  = 4;

   logic        clock;
   logic        reset;
   logic [31:0] in_Instruc, in_Pc, in_Alu;
   logic        in_Auto;
   logic [1:0]  in_Sel;
   logic        in_Freeze;
   logic        in_Next;
   logic [31:0] out_Display;
   logic [1:0]  out_Source;
   logic [7:0]  out_Blank;
   logic        out_Tick;

   display_sequencer #(.DWELL(DW), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_Instruc  (in_Instruc),
      .in_Pc       (in_Pc),
      .in_Alu      (in_Alu),
      .in_Auto     (in_Auto),
      .in_Sel      (in_Sel),
      .in_Freeze   (in_Freeze),
      .in_Next     (in_Next),
      .out_Display (out_Display),
      .out_Source  (out_Source),
      .out_Blank   (out_Blank),
      .out_Tick    (out_Tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] disp;
      logic [1:0]  src;
      logic [7:0]  blank;
      logic        tick;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: source index, dwell position, display word, and
   // the button levels sampled at the last three edges (newest first).
   int          m_src;
   int          m_cnt;
   logic [31:0] m_disp;
   bit          m_hist [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] blank_of(input logic [31:0] d);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 1; i < 8; i++) b[i] = ((d >> (4 * i)) == 32'd0);
      return b;
   endfunction

   function automatic void model_reset();
      m_src  = 0;
      m_cnt  = 0;
      m_disp = 32'd0;
      for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
   endfunction

   // Called at a negedge: apply inputs, predict the next edge, advance to next negedge.
   task automatic step(input bit a, input logic [1:0] s, input bit f, input bit n);
      exp_t e;
      bit   pulse;
      bit   tick;
      in_Auto   = a;
      in_Sel    = s;
      in_Freeze = f;
      in_Next   = n;
      pulse = m_hist[1] && !m_hist[2];
      tick  = 1'b0;
      if (!f) begin
         m_disp = (m_src == 1) ? in_Pc : (m_src == 2) ? in_Alu : in_Instruc;
         if (!a) begin
            m_src = (s == 2'd3) ? 0 : int'(s);
            m_cnt = 0;
         end else if (m_cnt == DW - 1 || pulse) begin
            m_src = (m_src + 1) % 3;
            m_cnt = 0;
            tick  = 1'b1;
         end else begin
            m_cnt++;
         end
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = n;
      e.disp  = m_disp;
      e.src   = 2'(m_src);
      e.blank = blank_of(m_disp);
      e.tick  = tick;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   // Asynchronous reset between edges, checked immediately, released on a negedge.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      chk("rst_source",  32'(out_Source), 32'd0);
      chk("rst_display", out_Display,     32'd0);
      chk("rst_blank",   32'(out_Blank),  32'h0000_00FE);
      chk("rst_tick",    32'(out_Tick),   32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: every edge that has a prediction is compared field by field.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("display", out_Display,     e.disp);
            chk("source",  32'(out_Source), 32'(e.src));
            chk("blank",   32'(out_Blank),  32'(e.blank));
            chk("tick",    32'(out_Tick),   32'(e.tick));
         end
      end
   end

   initial begin
      bit          a, f, n;
      logic [1:0]  s;
      reset      = 1'b0;
      in_Instruc = 32'h8C01_0004;
      in_Pc      = 32'h0000_0010;
      in_Alu     = 32'h0000_0000;
      in_Auto    = 1'b1;
      in_Sel     = 2'b00;
      in_Freeze  = 1'b0;
      in_Next    = 1'b0;
      model_reset();
      #1;
      chk("init_source", 32'(out_Source), 32'd0);
      chk("init_blank",  32'(out_Blank),  32'h0000_00FE);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Auto rotation over three full dwells.
      repeat (3 * DW + 3) step(1, 2'b00, 0, 0);

      // Held Next press (single advance), then a press timed onto expiry.
      repeat (5) step(1, 2'b00, 0, 1);
      repeat (4) step(1, 2'b00, 0, 0);
      for (int k = 0; k < 20 && m_cnt != DW - 4; k++) step(1, 2'b00, 0, 0);
      repeat (5) step(1, 2'b00, 0, 1);
      repeat (DW + 2) step(1, 2'b00, 0, 0);

      // Manual mode with Next activity that must be ignored.
      in_Alu = 32'h0000_0ABC;
      repeat (4) step(0, 2'b10, 0, 1);
      repeat (4) step(0, 2'b11, 0, 0);
      repeat (3) step(0, 2'b11, 0, 1);

      // Freeze while showing PC; data change and press must not show through.
      for (int k = 0; k < 20 && m_src != 1; k++) step(1, 2'b00, 0, 0);
      step(1, 2'b00, 0, 0);
      in_Pc = 32'hDEAD_BEEF;
      repeat (5)  step(1, 2'b00, 1, 1);
      repeat (15) step(1, 2'b00, 1, 0);
      repeat (2 * DW) step(1, 2'b00, 0, 0);

      // Auto -> manual mid-dwell, then back to auto.
      for (int k = 0; k < 20 && m_cnt != 2; k++) step(1, 2'b00, 0, 0);
      repeat (3) step(0, 2'b01, 0, 0);
      repeat (2 * DW + 2) step(1, 2'b00, 0, 0);

      // Reset while rotation shows the ALU word.
      for (int k = 0; k < 30 && !(m_src == 2 && m_cnt >= 1); k++) step(1, 2'b00, 0, 0);
      async_reset();

      // Randomized segments, with occasional resets anywhere including mid-freeze.
      n = 1'b0;
      for (int seg = 0; seg < 60; seg++) begin
         a = ($urandom_range(3) != 0);
         f = ($urandom_range(4) == 0);
         s = 2'($urandom_range(3));
         for (int c = 0; c < int'($urandom_range(12, 3)); c++) begin
            if ($urandom_range(3) == 0) in_Instruc = $urandom >> $urandom_range(31);
            if ($urandom_range(3) == 0) in_Pc      = $urandom >> $urandom_range(31);
            if ($urandom_range(3) == 0) in_Alu     = $urandom >> $urandom_range(31);
            if ($urandom_range(3) == 0) n = ~n;
            step(a, s, f, n);
         end
         if ($urandom_range(15) == 0) async_reset();
      end

      repeat (2) @(negedge clock);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
